// File: rtl/alu_iter_param_if.sv
// Issue/result bundle for alu_iter_param: start strobe with operands in, registered result and status out.
// The master drives en and the operands; the slave returns the result, busy and the done/illegal pulses.
interface alu_iter_param_if #(
   parameter int XLEN = 32
);
   logic            en;
   logic [11:0]     decinst;
   logic [XLEN-1:0] operando1;
   logic [XLEN-1:0] rs2;
   logic [XLEN-1:0] inm;
   logic [XLEN-1:0] salida_alu;
   logic            salida_comparativa;
   logic            carry;
   logic            busy;
   logic            done;
   logic            illegal;

   modport master (
      output en, decinst, operando1, rs2, inm,
      input  salida_alu, salida_comparativa, carry, busy, done, illegal
   );

   modport slave (
      input  en, decinst, operando1, rs2, inm,
      output salida_alu, salida_comparativa, carry, busy, done, illegal
   );
endinterface

// File: rtl/alu_iter_param.sv
// Iterative RV32I-style ALU: one-cycle ops, shifts take 1+ceil(shamt/SHIFT_STEP) cycles.
// No backpressure: en is sampled only while idle and dropped while busy, never queued.
module alu_iter_param #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rstn,
   alu_iter_param_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic            cmp_q, cmp_d;
   logic            carry_q, carry_d;
   logic            done_q, done_d;
   logic            ill_q, ill_d;
   logic            left_q, left_d;
   logic            arith_q, arith_d;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            alt;
   logic            is_reg;
   logic            legal;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic [SW-1:0]   shamt;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   diff;
   logic            lt_s;
   logic            lt_u;
   logic [CW-1:0]   step;
   logic [CW-1:0]   cnt_rem;
   logic [XLEN-1:0] shifted;
   logic            unused_dec;

   assign opcode     = bus.decinst[6:0];
   assign funct3     = bus.decinst[9:7];
   assign alt        = bus.decinst[10];
   assign unused_dec = bus.decinst[11];
   assign is_reg     = (opcode == OP_REG);
   assign legal      = is_reg || (opcode == OP_IMM);
   assign opa        = bus.operando1;
   assign opb        = is_reg ? bus.rs2 : bus.inm;
   assign shamt      = opb[SW-1:0];
   // The extra top bit is the carry-out; for subtraction it reads as "no borrow".
   assign sum        = {1'b0, opa} + {1'b0, opb};
   assign diff       = {1'b0, opa} + {1'b0, ~opb} + (XLEN+1)'(1);
   assign lt_s       = $signed(opa) < $signed(opb);
   assign lt_u       = opa < opb;

   always_comb begin
      step    = ({1'b0, cnt_q} < STEP_C) ? {1'b0, cnt_q} : STEP_C;
      cnt_rem = {1'b0, cnt_q} - step;
      if (left_q)
         shifted = acc_q << step;
      else if (arith_q)
         shifted = $unsigned($signed(acc_q) >>> step);
      else
         shifted = acc_q >> step;
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      carry_d = carry_q;
      left_d  = left_q;
      arith_d = arith_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               done_d  = 1'b1;
               cmp_d   = 1'b0;
               carry_d = 1'b0;
               res_d   = '0;
               if (!legal) begin
                  ill_d = 1'b1;
               end else begin
                  case (funct3)
                     3'b000: begin
                        if (is_reg && alt) {carry_d, res_d} = diff;
                        else               {carry_d, res_d} = sum;
                     end
                     3'b010: begin
                        res_d = {{(XLEN-1){1'b0}}, lt_s};
                        cmp_d = lt_s;
                     end
                     3'b011: begin
                        res_d = {{(XLEN-1){1'b0}}, lt_u};
                        cmp_d = lt_u;
                     end
                     3'b100:  res_d = opa ^ opb;
                     3'b110:  res_d = opa | opb;
                     3'b111:  res_d = opa & opb;
                     default: begin
                        // 001/101: a zero shift finishes now, otherwise hand off to SHIFT
                        if (shamt == '0) begin
                           res_d = opa;
                        end else begin
                           done_d  = 1'b0;
                           res_d   = res_q;
                           cmp_d   = cmp_q;
                           carry_d = carry_q;
                           acc_d   = opa;
                           cnt_d   = shamt;
                           left_d  = (funct3 == 3'b001);
                           arith_d = (funct3 == 3'b101) && alt;
                           state_d = SHIFT;
                        end
                     end
                  endcase
               end
            end
         end
         SHIFT: begin
            acc_d = shifted;
            cnt_d = cnt_rem[SW-1:0];
            if (cnt_rem == '0) begin
               res_d   = shifted;
               cmp_d   = 1'b0;
               carry_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         res_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         cmp_q   <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         carry_q <= carry_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         left_q  <= left_d;
         arith_q <= arith_d;
      end
   end

   assign bus.salida_alu         = res_q;
   assign bus.salida_comparativa = cmp_q;
   assign bus.carry              = carry_q;
   assign bus.busy               = (state_q == SHIFT);
   assign bus.done               = done_q;
   assign bus.illegal            = ill_q;
endmodule

// File: tb/tb_alu_iter_param.sv
// Bench for alu_iter_param: two instances (SHIFT_STEP 1 and 4) share directed stimulus;
// expected results and completion cycles are queued per instance and matched on done.
module tb_alu_iter_param;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef struct {
      logic [31:0] res;
      logic        cmp;
      logic        carry;
      logic        ill;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   exp_t qa[$];
   exp_t qb[$];

   alu_iter_param_if #(.XLEN(32)) ifa ();
   alu_iter_param_if #(.XLEN(32)) ifb ();

   alu_iter_param #(.XLEN(32), .SHIFT_STEP(1)) u_dut_s1 (.clk(clk), .rstn(rstn), .bus(ifa));
   alu_iter_param #(.XLEN(32), .SHIFT_STEP(4)) u_dut_s4 (.clk(clk), .rstn(rstn), .bus(ifb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      else passed++;
   endtask

   task automatic drive(input logic en, input logic [11:0] dec, input logic [31:0] a,
                        input logic [31:0] r, input logic [31:0] i);
      ifa.en = en; ifa.decinst = dec; ifa.operando1 = a; ifa.rs2 = r; ifa.inm = i;
      ifb.en = en; ifb.decinst = dec; ifb.operando1 = a; ifb.rs2 = r; ifb.inm = i;
   endtask

   task automatic mon(input int d, input logic done, input logic busy, input logic ill,
                      input logic cmp, input logic carry, input logic [31:0] res);
      exp_t  e;
      string t;
      int    qs;
      if (!done) return;
      t  = (d == 0) ? "s1" : "s4";
      qs = (d == 0) ? qa.size() : qb.size();
      check({t, "_busy_with_done"}, busy, 0);
      check({t, "_expected_pending"}, (qs != 0), 1);
      if (qs == 0) return;
      if (d == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      check({t, "_done_cycle"}, cyc, e.cyc);
      check({t, "_salida_alu"}, res, e.res);
      check({t, "_comparativa"}, cmp, e.cmp);
      check({t, "_carry"}, carry, e.carry);
      check({t, "_illegal"}, ill, e.ill);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         mon(0, ifa.done, ifa.busy, ifa.illegal, ifa.salida_comparativa, ifa.carry, ifa.salida_alu);
         mon(1, ifb.done, ifb.busy, ifb.illegal, ifb.salida_comparativa, ifb.carry, ifb.salida_alu);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((ifa.busy || ifb.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", (ifa.busy || ifb.busy), 0);
   endtask

   // Issue one op at the current falling edge; latency is derived from the shift amount.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                        input logic [31:0] a, input logic [31:0] r, input logic [31:0] i,
                        input logic [31:0] xres, input logic xcmp, input logic xcarry,
                        input logic xill);
      exp_t        e;
      logic [31:0] b;
      int          sh;
      int          l1;
      int          l4;
      wait_idle();
      b  = (op == OP_REG) ? r : i;
      sh = int'(b[4:0]);
      l1 = 1;
      l4 = 1;
      if (!xill && (f3 == 3'b001 || f3 == 3'b101) && sh != 0) begin
         l1 = 1 + sh;
         l4 = 1 + (sh + 3) / 4;
      end
      drive(1'b1, {f3[0], alt, f3, op}, a, r, i);
      e.res = xres; e.cmp = xcmp; e.carry = xcarry; e.ill = xill;
      e.cyc = cyc + l1; qa.push_back(e);
      e.cyc = cyc + l4; qb.push_back(e);
      @(negedge clk);
      ifa.en = 1'b0;
      ifb.en = 1'b0;
   endtask

   initial begin
      drive(1'b0, 12'h000, 32'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      check("rst_s1_alu", ifa.salida_alu, 0);
      check("rst_s1_flags", {ifa.salida_comparativa, ifa.carry, ifa.busy, ifa.done, ifa.illegal}, 0);
      check("rst_s4_alu", ifb.salida_alu, 0);
      check("rst_s4_flags", {ifb.salida_comparativa, ifb.carry, ifb.busy, ifb.done, ifb.illegal}, 0);
      rstn = 1'b1;
      @(negedge clk);

      issue(OP_REG, 3'b000, 0, 32'hc0404040, 32'h00000fff, 32'h0, 32'hc040503f, 0, 0, 0);
      issue(OP_REG, 3'b000, 1, 32'hc0404040, 32'h00000fff, 32'h0, 32'hc0403041, 0, 1, 0);
      issue(OP_IMM, 3'b010, 0, 32'hc0404040, 32'h0, 32'h00000fff, 32'h00000001, 1, 0, 0);
      issue(OP_IMM, 3'b011, 0, 32'hc0404040, 32'h0, 32'h00000fff, 32'h00000000, 0, 0, 0);
      // SRAI by 31, with a stray start (different operands) pulsed while busy
      issue(OP_IMM, 3'b101, 1, 32'hc0404040, 32'h0, 32'h00000fff, 32'hffffffff, 0, 0, 0);
      repeat (2) @(negedge clk);
      drive(1'b1, {1'b0, 1'b0, 3'b000, OP_REG}, 32'h11111111, 32'h22222222, 32'h0);
      @(negedge clk);
      drive(1'b0, 12'h000, 32'h0, 32'h0, 32'h0);
      issue(OP_IMM, 3'b001, 0, 32'h89abcdef, 32'h0, 32'h00000000, 32'h89abcdef, 0, 0, 0);
      issue(OP_BR,  3'b000, 0, 32'hc0404040, 32'h00000fff, 32'h0, 32'h00000000, 0, 0, 1);
      issue(OP_REG, 3'b100, 0, 32'hf0f0f0f0, 32'h0ff00ff0, 32'h0, 32'hff00ff00, 0, 0, 0);
      issue(OP_IMM, 3'b110, 0, 32'h12340000, 32'h0, 32'h00005678, 32'h12345678, 0, 0, 0);
      issue(OP_REG, 3'b111, 0, 32'hffff0000, 32'h0f0f0f0f, 32'h0, 32'h0f0f0000, 0, 0, 0);
      issue(OP_REG, 3'b101, 0, 32'h80000000, 32'h00000004, 32'h0, 32'h08000000, 0, 0, 0);
      issue(OP_REG, 3'b101, 1, 32'h80000000, 32'h00000004, 32'h0, 32'hf8000000, 0, 0, 0);
      issue(OP_REG, 3'b001, 0, 32'h00000001, 32'hffffffe5, 32'h0, 32'h00000020, 0, 0, 0);
      issue(OP_IMM, 3'b101, 1, 32'h80000000, 32'h0, 32'h00000007, 32'hff000000, 0, 0, 0);
      issue(OP_REG, 3'b000, 0, 32'hffffffff, 32'h00000001, 32'h0, 32'h00000000, 0, 1, 0);
      issue(OP_IMM, 3'b000, 1, 32'h00000005, 32'h0, 32'h00000003, 32'h00000008, 0, 0, 0);
      issue(OP_REG, 3'b010, 0, 32'h00000001, 32'hffffffff, 32'h0, 32'h00000000, 0, 0, 0);
      issue(OP_REG, 3'b011, 0, 32'h00000001, 32'hffffffff, 32'h0, 32'h00000001, 1, 0, 0);
      issue(OP_REG, 3'b000, 1, 32'h00000001, 32'h00000002, 32'h0, 32'hffffffff, 0, 0, 0);

      // Reset five cycles into a long SRAI: the op is lost, no done may follow
      issue(OP_IMM, 3'b101, 1, 32'hc0404040, 32'h0, 32'h00000fff, 32'hffffffff, 0, 0, 0);
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_s1_alu", ifa.salida_alu, 0);
      check("midrst_s1_flags", {ifa.salida_comparativa, ifa.carry, ifa.busy, ifa.done, ifa.illegal}, 0);
      check("midrst_s4_alu", ifb.salida_alu, 0);
      check("midrst_s4_flags", {ifb.salida_comparativa, ifb.carry, ifb.busy, ifb.done, ifb.illegal}, 0);
      qa.delete();
      qb.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      issue(OP_REG, 3'b000, 0, 32'hc0404040, 32'h00000fff, 32'h0, 32'hc040503f, 0, 0, 0);

      for (int n = 0; n < 100 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
      repeat (40) @(negedge clk);
      check("s1_pending_at_end", qa.size(), 0);
      check("s4_pending_at_end", qb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
